// File: rtl/common_types_pkg.sv
// Shared types for the core's memory path: data word, byte strobes and the
// memory controller state encoding.
package common_types_pkg;

   typedef logic [31:0] word_t;
   typedef logic [3:0]  strobe_t;

   typedef enum logic [1:0] {
      IDLE,
      DACC,
      IACC
   } memctl_state_t;

   localparam strobe_t STROBE_ALL = 4'hF;

   // RAM byte enables for an access: stores use the requester's strobes,
   // loads and fetches always read the full word.
   function automatic strobe_t access_strobe(input logic wen, input strobe_t strobe);
      return wen ? strobe : STROBE_ALL;
   endfunction

endpackage

// File: rtl/memory_control.sv
// Arbitrates instruction fetch and data access onto one single-port RAM.
// A data access is always followed by a fetch so ihit/dhit land together.
module memory_control
   import common_types_pkg::*;
(
   input  logic        clk,
   input  logic        n_rst,
   input  logic        halt,
   input  logic        iren,
   input  logic [31:0] iaddr,
   input  logic        dread,
   input  logic        dwrite,
   input  logic [31:0] daddr,
   input  logic [31:0] dstore,
   input  logic [3:0]  dstrobe,
   output logic        ihit,
   output logic        dhit,
   output logic [31:0] iload,
   output logic [31:0] dload,
   output logic        ram_ren,
   output logic        ram_wen,
   output logic [31:0] ram_addr,
   output logic [31:0] ram_store,
   output logic [3:0]  ram_strobe,
   input  logic [31:0] ram_load,
   input  logic        ram_ready
);

   memctl_state_t state_q, state_d;
   word_t         a_addr_q, a_addr_d;
   word_t         a_store_q, a_store_d;
   strobe_t       a_strobe_q, a_strobe_d;
   logic          a_wen_q, a_wen_d;
   logic          d_done_q, d_done_d;
   word_t         dload_q, dload_d;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q    <= IDLE;
         a_addr_q   <= '0;
         a_store_q  <= '0;
         a_strobe_q <= '0;
         a_wen_q    <= 1'b0;
         d_done_q   <= 1'b0;
         dload_q    <= '0;
      end else begin
         state_q    <= state_d;
         a_addr_q   <= a_addr_d;
         a_store_q  <= a_store_d;
         a_strobe_q <= a_strobe_d;
         a_wen_q    <= a_wen_d;
         d_done_q   <= d_done_d;
         dload_q    <= dload_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      a_addr_d   = a_addr_q;
      a_store_d  = a_store_q;
      a_strobe_d = a_strobe_q;
      a_wen_d    = a_wen_q;
      d_done_d   = d_done_q;
      dload_d    = dload_q;
      ram_ren    = 1'b0;
      ram_wen    = 1'b0;
      ram_addr   = '0;
      ram_store  = '0;
      ram_strobe = '0;
      ihit       = 1'b0;
      iload      = '0;

      unique case (state_q)
         IDLE: begin
            // d_done set means this data request was already served and only
            // the paired fetch is outstanding.
            if (!halt) begin
               if ((dread || dwrite) && !d_done_q) begin
                  a_addr_d   = daddr;
                  a_store_d  = dstore;
                  a_strobe_d = dstrobe;
                  a_wen_d    = dwrite;
                  state_d    = DACC;
               end else if (iren) begin
                  a_addr_d = iaddr;
                  a_wen_d  = 1'b0;
                  state_d  = IACC;
               end
            end
         end

         DACC: begin
            ram_ren    = ~a_wen_q;
            ram_wen    = a_wen_q;
            ram_addr   = a_addr_q;
            ram_store  = a_store_q;
            ram_strobe = access_strobe(a_wen_q, a_strobe_q);
            if (ram_ready) begin
               if (!a_wen_q) begin
                  dload_d = ram_load;
               end
               d_done_d = 1'b1;
               // Chain straight into the fetch, regardless of halt.
               if (iren) begin
                  a_addr_d = iaddr;
                  a_wen_d  = 1'b0;
                  state_d  = IACC;
               end else begin
                  state_d = IDLE;
               end
            end
         end

         IACC: begin
            ram_ren    = 1'b1;
            ram_addr   = a_addr_q;
            ram_strobe = STROBE_ALL;
            if (ram_ready) begin
               ihit     = 1'b1;
               iload    = ram_load;
               d_done_d = 1'b0;
               state_d  = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign dhit  = ihit & d_done_q;
   assign dload = dload_q;

endmodule

// File: tb/tb_memory_control.sv
// Directed bench for memory_control with an in-bench RAM whose ready latency
// is programmable separately for the instruction (<0x1000) and data regions.
module tb_memory_control;

   logic        clk;
   logic        n_rst;
   logic        halt;
   logic        iren;
   logic [31:0] iaddr;
   logic        dread;
   logic        dwrite;
   logic [31:0] daddr;
   logic [31:0] dstore;
   logic [3:0]  dstrobe;
   logic        ihit;
   logic        dhit;
   logic [31:0] iload;
   logic [31:0] dload;
   logic        ram_ren;
   logic        ram_wen;
   logic [31:0] ram_addr;
   logic [31:0] ram_store;
   logic [3:0]  ram_strobe;
   logic [31:0] ram_load;
   logic        ram_ready;

   int total = 0;
   int bad   = 0;

   memory_control dut (
      .clk       (clk),
      .n_rst     (n_rst),
      .halt      (halt),
      .iren      (iren),
      .iaddr     (iaddr),
      .dread     (dread),
      .dwrite    (dwrite),
      .daddr     (daddr),
      .dstore    (dstore),
      .dstrobe   (dstrobe),
      .ihit      (ihit),
      .dhit      (dhit),
      .iload     (iload),
      .dload     (dload),
      .ram_ren   (ram_ren),
      .ram_wen   (ram_wen),
      .ram_addr  (ram_addr),
      .ram_store (ram_store),
      .ram_strobe(ram_strobe),
      .ram_load  (ram_load),
      .ram_ready (ram_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM model
   logic [31:0] mem [0:16383];
   int          cnt;
   int          lat_i;
   int          lat_d;
   int          cur_lat;
   logic        hold_ready;
   logic        poke_en;
   logic [31:0] poke_addr;
   logic [31:0] poke_data;
   logic        ram_en;

   assign ram_en    = ram_ren | ram_wen;
   assign cur_lat   = (ram_addr < 32'h1000) ? lat_i : lat_d;
   assign ram_ready = ram_en && !hold_ready && (cnt == cur_lat - 1);
   assign ram_load  = ram_ren ? mem[ram_addr[15:2]] : 32'h0;

   always @(posedge clk) begin
      if (!ram_en || ram_ready) cnt <= 0;
      else cnt <= cnt + 1;
      if (poke_en) mem[poke_addr[15:2]] <= poke_data;
      if (ram_wen && ram_ready) begin
         for (int b = 0; b < 4; b++) begin
            if (ram_strobe[b]) mem[ram_addr[15:2]][8*b +: 8] <= ram_store[8*b +: 8];
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic poke(input logic [31:0] a, input logic [31:0] d);
      poke_en   = 1'b1;
      poke_addr = a;
      poke_data = d;
      cyc();
      poke_en = 1'b0;
   endtask

   task automatic idle_inputs();
      iren = 0; dread = 0; dwrite = 0; halt = 0;
   endtask

   initial begin
      n_rst = 0; halt = 0; iren = 0; iaddr = 0; dread = 0; dwrite = 0;
      daddr = 0; dstore = 0; dstrobe = 0;
      lat_i = 1; lat_d = 1; hold_ready = 0; poke_en = 0; poke_addr = 0; poke_data = 0;
      cnt = 0;

      poke(32'h100, 32'h00500093);
      poke(32'h104, 32'h00A00113);
      poke(32'h2000, 32'hDEADBEEF);
      poke(32'h2004, 32'h12345678);
      poke(32'h3000, 32'hAABBCCDD);
      #1;
      chk("rst_ihit", {31'b0, ihit}, 32'h0);
      chk("rst_dload", dload, 32'h0);
      chk("rst_ren", {30'b0, ram_ren, ram_wen}, 32'h0);
      n_rst = 1;

      // Reset mid-DACC
      cyc();
      hold_ready = 1; dwrite = 1; daddr = 32'h3000; dstore = 32'h55; dstrobe = 4'hF;
      cyc();
      #1 chk("rmid_wen_on", {31'b0, ram_wen}, 32'h1);
      n_rst = 0;
      #1 chk("rmid_wen_async", {31'b0, ram_wen}, 32'h0);
      dwrite = 0; hold_ready = 0;
      #5 n_rst = 1;
      cyc();
      #1 chk("rmid_dhit", {30'b0, dhit, ihit}, 32'h0);
      chk("rmid_idle", {30'b0, ram_ren, ram_wen}, 32'h0);
      cyc();

      // Fetch, L=1
      iren = 1; iaddr = 32'h100;
      #1 chk("f_c0_ihit", {31'b0, ihit}, 32'h0);
      cyc();
      iren = 0;
      #1 chk("f_c1_ihit", {31'b0, ihit}, 32'h1);
      chk("f_c1_iload", iload, 32'h00500093);
      chk("f_c1_addr", ram_addr, 32'h100);
      cyc();
      #1 chk("f_c2_ihit", {31'b0, ihit}, 32'h0);
      chk("f_c2_ren", {31'b0, ram_ren}, 32'h0);

      // Load, Ld=3, Li=2
      lat_d = 3; lat_i = 2;
      cyc();
      dread = 1; daddr = 32'h2000; iren = 1; iaddr = 32'h104;
      #1 chk("ld_c0_hit", {30'b0, dhit, ihit}, 32'h0);
      for (int c = 1; c <= 3; c++) begin
         cyc();
         #1 chk("ld_dacc_ren", {30'b0, ram_ren, ram_wen}, 32'h2);
         chk("ld_dacc_addr", ram_addr, 32'h2000);
         chk("ld_dacc_hit", {30'b0, dhit, ihit}, 32'h0);
      end
      cyc();
      #1 chk("ld_c4_addr", ram_addr, 32'h104);
      chk("ld_c4_ren", {31'b0, ram_ren}, 32'h1);
      chk("ld_c4_hit", {30'b0, dhit, ihit}, 32'h0);
      chk("ld_c4_dload", dload, 32'hDEADBEEF);
      cyc();
      #1 chk("ld_c5_hit", {30'b0, dhit, ihit}, 32'h3);
      chk("ld_c5_iload", iload, 32'h00A00113);
      cyc();
      idle_inputs();
      #1 chk("ld_c6_hit", {30'b0, dhit, ihit}, 32'h0);
      chk("ld_c6_ren", {31'b0, ram_ren}, 32'h0);
      chk("ld_c6_dload", dload, 32'hDEADBEEF);

      // Store with strobe
      lat_d = 1; lat_i = 1;
      cyc();
      dwrite = 1; daddr = 32'h3000; dstore = 32'h11223344; dstrobe = 4'b0011;
      iren = 1; iaddr = 32'h100;
      cyc();
      #1 chk("st_wen", {30'b0, ram_ren, ram_wen}, 32'h1);
      chk("st_strobe", {28'b0, ram_strobe}, 32'h3);
      chk("st_store", ram_store, 32'h11223344);
      chk("st_addr", ram_addr, 32'h3000);
      chk("st_c1_hit", {30'b0, dhit, ihit}, 32'h0);
      cyc();
      #1 chk("st_c2_hit", {30'b0, dhit, ihit}, 32'h3);
      chk("st_c2_iload", iload, 32'h00500093);
      chk("st_dload_kept", dload, 32'hDEADBEEF);
      cyc();
      idle_inputs();
      #1 chk("st_mem", mem[32'h3000 >> 2], 32'hAABB3344);

      // Halt during IACC
      lat_i = 2;
      cyc();
      iren = 1; iaddr = 32'h104;
      cyc();
      halt = 1;
      #1 chk("h_c1_ihit", {31'b0, ihit}, 32'h0);
      cyc();
      #1 chk("h_c2_ihit", {31'b0, ihit}, 32'h1);
      chk("h_c2_iload", iload, 32'h00A00113);
      for (int c = 0; c < 3; c++) begin
         cyc();
         #1 chk("h_blocked", {29'b0, ram_ren, ram_wen, ihit}, 32'h0);
      end
      idle_inputs();

      // Simultaneous dread & dwrite
      lat_i = 1;
      cyc();
      dread = 1; dwrite = 1; daddr = 32'h40; dstore = 32'hCAFEF00D; dstrobe = 4'hF;
      iren = 1; iaddr = 32'h100;
      cyc();
      #1 chk("rw_wen", {30'b0, ram_ren, ram_wen}, 32'h1);
      chk("rw_addr", ram_addr, 32'h40);
      cyc();
      #1 chk("rw_hit", {30'b0, dhit, ihit}, 32'h3);
      cyc();
      idle_inputs();
      #1 chk("rw_mem", mem[32'h40 >> 2], 32'hCAFEF00D);
      chk("rw_dload_kept", dload, 32'hDEADBEEF);

      // Load with no fetch pending: dhit waits for the later fetch
      cyc();
      dread = 1; daddr = 32'h2004;
      cyc();
      #1 chk("nf_dacc", {30'b0, ram_ren, ram_wen}, 32'h2);
      cyc();
      iren = 1; iaddr = 32'h104;
      #1 chk("nf_idle", {29'b0, ram_ren, dhit, ihit}, 32'h0);
      chk("nf_dload", dload, 32'h12345678);
      cyc();
      #1 chk("nf_hit", {30'b0, dhit, ihit}, 32'h3);
      chk("nf_iload", iload, 32'h00A00113);
      cyc();
      idle_inputs();
      #1 chk("nf_after", {29'b0, ram_ren, dhit, ihit}, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running want finished");
      $fatal(1, "timeout");
   end

endmodule
